// File: rtl/vec_alu_pkg.sv
// vec_alu_pkg: op codes, legality check and FSM state type shared by the vector ALU sequencer.
package vec_alu_pkg;

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b011;
    localparam logic [2:0] OP_SHR  = 3'b111;

    typedef enum logic [1:0] {IDLE, RUN, FIN} seq_state_t;

    function automatic logic is_legal_op(input logic [2:0] op);
        return op inside {OP_PASS, OP_SUB, OP_MUL, OP_ADD, OP_SHR};
    endfunction

endpackage

// File: rtl/vec_beat_counter.sv
// vec_beat_counter: beat index over NBEATS beats, wrapping to 0 after the last one.
module vec_beat_counter #(
    parameter int NBEATS = 4,
    parameter int BW     = NBEATS > 1 ? $clog2(NBEATS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    output logic [BW-1:0] beat,
    output logic          last
);

    logic [BW-1:0] beat_q, beat_d;

    assign last   = beat_q == BW'(NBEATS - 1);
    assign beat   = beat_q;
    assign beat_d = clr ? '0 : en ? (last ? '0 : beat_q + 1'b1) : beat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) beat_q <= '0;
        else        beat_q <= beat_d;
    end

endmodule

// File: rtl/vector_alu_sequencer.sv
// vector_alu_sequencer: issues one vector op over VLEN elements through LANES shared
// scalar ALU lanes, one beat of LANES elements per cycle, and collects the results.
module vector_alu_sequencer
    import vec_alu_pkg::*;
#(
    parameter int VLEN  = 8,
    parameter int LANES = 2,
    parameter int W     = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [2:0]          op_in,
    input  logic                vcsub_in,
    input  logic [VLEN*W-1:0]   src_a,
    input  logic [VLEN*W-1:0]   src_b,
    input  logic                stall,
    output logic [2:0]          lane_op,
    output logic                lane_vcsub,
    output logic [LANES*W-1:0]  lane_a,
    output logic [LANES*W-1:0]  lane_b,
    input  logic [LANES*W-1:0]  lane_res,
    output logic                ready,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [VLEN*W-1:0]   result
);

    localparam int NBEATS = (VLEN + LANES - 1) / LANES;
    localparam int BW     = NBEATS > 1 ? $clog2(NBEATS) : 1;

    seq_state_t        state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic              vcsub_q, vcsub_d, err_q, err_d;
    logic [VLEN*W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [BW-1:0]     beat;
    logic              last, run, accept, legal;

    assign run    = state_q == RUN;
    assign accept = start && !run;
    assign legal  = is_legal_op(op_in);
    assign ready  = !run;
    assign busy   = run;
    assign done   = state_q == FIN;
    assign err    = err_q;
    assign result = res_q;

    vec_beat_counter #(.NBEATS(NBEATS), .BW(BW)) u_beat (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (run && !stall),
        .beat  (beat),
        .last  (last)
    );

    // Element e rides lane e%LANES during beat e/LANES; unused lanes of a partial beat stay 0.
    always_comb begin
        lane_a     = '0;
        lane_b     = '0;
        lane_op    = run ? op_q : OP_PASS;
        lane_vcsub = run && vcsub_q;
        for (int e = 0; e < VLEN; e++) begin
            if (run && beat == BW'(e / LANES)) begin
                lane_a[(e % LANES)*W +: W] = a_q[e*W +: W];
                lane_b[(e % LANES)*W +: W] = b_q[e*W +: W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        vcsub_d = vcsub_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        err_d   = err_q;
        case (state_q)
            RUN: begin
                if (!stall) begin
                    for (int e = 0; e < VLEN; e++)
                        if (beat == BW'(e / LANES)) res_d[e*W +: W] = lane_res[(e % LANES)*W +: W];
                    if (last) state_d = FIN;
                end
            end
            default: begin
                state_d = IDLE;
                if (accept) begin
                    err_d   = !legal;
                    res_d   = '0;
                    state_d = legal ? RUN : FIN;
                    if (legal) begin
                        op_d    = op_in;
                        vcsub_d = vcsub_in;
                        a_d     = src_a;
                        b_d     = src_b;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= OP_PASS;
            vcsub_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            vcsub_q <= vcsub_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

endmodule
